// File: rtl/branch_pkg.sv
// Shared types and constants for the branch-decision register and its
// optional flush extension.
package branch_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } branch_state_t;

    localparam int BRANCH_CNT_W         = 4;
    localparam int BRANCH_FLUSH_DEFAULT = 1;

endpackage : branch_pkg

// File: rtl/branch_flush_counter.sv
// Loadable down-counter that saturates at zero; async active-low clear.
// Used by branch_unit only when BRANCH_FLUSH_EN is defined.
module branch_flush_counter
    import branch_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [BRANCH_CNT_W-1:0] load_val,
    input  logic                    dec,
    output logic [BRANCH_CNT_W-1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule : branch_flush_counter

// File: rtl/branch_unit.sv
// Registered branch-taken strobe (s1 & s2) for the PC-source mux.
// Define BRANCH_FLUSH_EN to hold r for FLUSH_CYCLES cycles and drop new requests meanwhile.
module branch_unit
    import branch_pkg::*;
#(
    parameter int FLUSH_CYCLES = BRANCH_FLUSH_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic s1,
    input  logic s2,
    output logic r
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_cfg
        $error("branch_unit: FLUSH_CYCLES must be in 1..15");
    end

    // Bitwise AND: s1 = 0 forces 0 even when the zero flag is X.
    logic taken;
    assign taken = s1 & s2;

`ifdef BRANCH_FLUSH_EN
    localparam logic [BRANCH_CNT_W-1:0] CNT_INIT = BRANCH_CNT_W'(FLUSH_CYCLES - 1);

    branch_state_t           state, state_next;
    logic [BRANCH_CNT_W-1:0] cnt;
    logic                    cnt_load, cnt_dec, r_next;

    branch_flush_counter u_flush_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (CNT_INIT),
        .dec      (cnt_dec),
        .cnt      (cnt)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            r     <= 1'b0;
        end else begin
            state <= state_next;
            r     <= r_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (taken && (FLUSH_CYCLES > 1)) state_next = FLUSH;
            FLUSH:   if (cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Requests are ignored while flushing; they are dropped, not queued.
    always_comb begin
        r_next   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state)
            IDLE: begin
                r_next   = taken;
                cnt_load = taken;
            end
            FLUSH: begin
                r_next  = (cnt != '0);
                cnt_dec = (cnt != '0);
            end
            default: ;
        endcase
    end
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r <= 1'b0;
        end else begin
            r <= taken;
        end
    end
`endif

endmodule : branch_unit

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit; a behavioural model feeds an expected-value
// queue that is drained after each rising edge. Flush checks run when BRANCH_FLUSH_EN is defined.
module tb_branch_unit;
    import branch_pkg::*;

`ifdef BRANCH_FLUSH_EN
    localparam int FC = 3;
`else
    localparam int FC = 1;
`endif

    logic clock = 1'b0;
    logic reset_n, s1, s2;
    logic r;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_q[$];

    bit   m_flush;
    int   m_cnt;
    logic m_r;

    branch_unit #(.FLUSH_CYCLES(FC)) dut (
        .clock(clock), .reset_n(reset_n), .s1(s1), .s2(s2), .r(r)
    );

`ifdef BRANCH_FLUSH_EN
    logic r_eq, r4;
    branch_unit #(.FLUSH_CYCLES(1)) dut_eq (
        .clock(clock), .reset_n(reset_n), .s1(s1), .s2(s2), .r(r_eq)
    );
    branch_unit #(.FLUSH_CYCLES(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .s1(s1), .s2(s2), .r(r4)
    );
`endif

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flush = 1'b0;
        m_cnt   = 0;
        m_r     = 1'b0;
    endtask

    // Behaviour of one rising edge, written from the decision/flush rules.
    task automatic model_edge(input logic t);
        if (!reset_n) begin
            model_reset();
        end else if (!m_flush) begin
            m_r = t;
            if (t) begin
                m_cnt   = FC - 1;
                m_flush = (FC > 1);
            end
        end else if (m_cnt != 0) begin
            m_r   = 1'b1;
            m_cnt = m_cnt - 1;
        end else begin
            m_r     = 1'b0;
            m_flush = 1'b0;
        end
    endtask

    // Drive inputs mid-cycle, predict, then compare 1 time unit after the edge.
    task automatic step(input logic a, input logic b, input string tag);
        logic t, e;
        @(negedge clock);
        s1 = a;
        s2 = b;
        t  = (a === 1'b0) ? 1'b0 : (a & b);
        model_edge(t);
        exp_q.push_back(m_r);
`ifdef BRANCH_FLUSH_EN
        e = reset_n ? t : 1'b0;
`endif
        @(posedge clock);
        #1;
`ifdef BRANCH_FLUSH_EN
        check("equiv_fc1", r_eq, e);
`endif
        if (exp_q.size() == 0) begin
            check({tag, "_underflow"}, 1'b1, 1'b0);
        end else begin
            e = exp_q.pop_front();
            check(tag, r, e);
        end
    endtask

    initial begin
        model_reset();
        reset_n = 1'b0;
        s1 = 1'b1;
        s2 = 1'b1;
        #1;
        check("rst_initial", r, 1'b0);

        // Reset held over three edges with a request present.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "rst_hold");
        reset_n = 1'b1;
        step(1'b1, 1'b1, "rst_release");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "drain");

        // Truth table plus s2 = X with s1 = 0.
        step(1'b0, 1'b0, "tt_00");
        step(1'b0, 1'b1, "tt_01");
        step(1'b1, 1'b0, "tt_10");
        step(1'b1, 1'b1, "tt_11");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "drain");
        step(1'b0, 1'bx, "tt_0x");

        // Latency and between-edge changes.
        step(1'b1, 1'b0, "lat_s2_0");
        #2;
        s2 = 1'b1;
        #1;
        check("no_comb_path", r, m_r);
        s2 = 1'b0;
        step(1'b1, 1'b1, "lat_s2_1");
        #2;
        s1 = 1'b0;
        #1;
        check("hold_between_edges", r, m_r);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "drain");

        // One-cycle request, then a request held across the flush window.
        step(1'b1, 1'b1, "pulse_start");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "pulse_tail");
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, "b2b_hold");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "drain");

        // Reset asserted two cycles into a flush.
        step(1'b1, 1'b1, "midrst_start");
        step(1'b0, 1'b0, "midrst_flush");
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_async", r, 1'b0);
`ifdef BRANCH_FLUSH_EN
        check("midrst_async_fc4", r4, 1'b0);
`endif
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, "midrst_after");
`ifdef BRANCH_FLUSH_EN
            check("midrst_after_fc4", r4, 1'b0);
`endif
        end

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end

        check("queue_empty", 1'(exp_q.size() == 0), 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_branch_unit
